// File: rtl/dmem_bhw.sv
// rtl/dmem_bhw.sv - byte/half/word data memory with misaligned-half spanning
// Half accesses at offset 3 take a second cycle to reach lane 0 of the next word.
module dmem_bhw #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 1024
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req,
  input  logic            we,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] wd,
  input  logic [1:0]      size,
  input  logic            lunsigned,
  output logic            ready,
  output logic            rvalid,
  output logic [XLEN-1:0] rd,
  output logic            err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, SPAN_WR, SPAN_RD} state_t;

  state_t          r_state;
  logic [31:0]     r_mem [DEPTH];
  logic [AW-1:0]   r_idx;
  logic [7:0]      r_hi;
  logic [7:0]      r_lo;
  logic            r_lu;
  logic            r_rvalid;
  logic            r_err;
  logic [XLEN-1:0] r_rd;

  logic            w_wen;
  logic [AW-1:0]   w_widx;
  logic [31:0]     w_wdata;
  logic [3:0]      w_wbe;

  wire             w_idle     = (r_state == IDLE);
  wire             w_accept   = req && w_idle;
  wire [AW-1:0]    w_idx      = a[AW+1:2];
  wire [1:0]       w_off      = a[1:0];
  wire [4:0]       w_sh       = {w_off, 3'b000};
  wire             w_is_byte  = (size == 2'b01);
  wire             w_is_half  = (size == 2'b10);
  wire             w_is_word  = !w_is_byte && !w_is_half;
  wire [AW-1:0]    w_idx_nxt  = r_idx + AW'(1);
  wire [31:0]      w_rword    = r_mem[w_idx];
  wire [15:0]      w_rsub     = 16'(w_rword >> w_sh);
  wire [7:0]       w_rnext_b0 = r_mem[w_idx_nxt][7:0];
  wire             w_unused   = ^a[XLEN-1:AW+2];

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic u);
    return u ? {24'b0, b} : {{24{b[7]}}, b};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic u);
    return u ? {16'b0, h} : {{16{h[15]}}, h};
  endfunction

  // Single write port: either the first access of an accepted store or the
  // deferred lane-0 byte of a spanning half store.
  always_comb begin
    w_wen   = 1'b0;
    w_widx  = w_idx;
    w_wdata = {4{wd[7:0]}};
    w_wbe   = 4'b0000;
    if (r_state == SPAN_WR) begin
      w_wen   = 1'b1;
      w_widx  = w_idx_nxt;
      w_wdata = {4{r_hi}};
      w_wbe   = 4'b0001;
    end else if (w_accept && we) begin
      if (w_is_byte) begin
        w_wen = 1'b1;
        w_wbe = 4'b0001 << w_off;
      end else if (w_is_half) begin
        w_wen = 1'b1;
        if (w_off == 2'd3) begin
          w_wbe = 4'b1000;
        end else begin
          w_wdata = {16'b0, wd[15:0]} << w_sh;
          w_wbe   = 4'b0011 << w_off;
        end
      end else if (w_off == 2'd0) begin
        w_wen   = 1'b1;
        w_wdata = wd[31:0];
        w_wbe   = 4'b1111;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wen && rstn) begin
      for (int i = 0; i < 4; i++) begin
        if (w_wbe[i]) r_mem[w_widx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= IDLE;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_rd     <= '0;
      r_idx    <= '0;
      r_hi     <= 8'h00;
      r_lo     <= 8'h00;
      r_lu     <= 1'b0;
    end else begin
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req) begin
            r_idx <= w_idx;
            r_hi  <= wd[15:8];
            r_lu  <= lunsigned;
            if (w_is_word && (w_off != 2'd0)) begin
              r_err <= 1'b1;
              if (!we) begin
                r_rvalid <= 1'b1;
                r_rd     <= '0;
              end
            end else if (w_is_half && (w_off == 2'd3)) begin
              r_lo    <= w_rword[31:24];
              r_state <= we ? SPAN_WR : SPAN_RD;
            end else if (!we) begin
              r_rvalid <= 1'b1;
              if (w_is_byte)      r_rd <= ext8(w_rsub[7:0], lunsigned);
              else if (w_is_half) r_rd <= ext16(w_rsub, lunsigned);
              else                r_rd <= w_rword;
            end
          end
        end
        SPAN_WR: r_state <= IDLE;
        SPAN_RD: begin
          r_state  <= IDLE;
          r_rvalid <= 1'b1;
          r_rd     <= ext16({w_rnext_b0, r_lo}, r_lu);
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ready  = w_idle;
  assign rvalid = r_rvalid;
  assign err    = r_err;
  assign rd     = r_rd;

endmodule

// File: doc/dmem_bhw.md
DMEM_BHW -- requirements
Module: dmem_bhw

Interface
REQ-001 Parameter XLEN, default 32, data width; only 32 is supported.
REQ-002 Parameter DEPTH, default 1024, number of 32-bit words; SHALL be a power of two of at least 2.
REQ-003 Derived AW = log2(DEPTH), the word-index width.
REQ-004 clk  in  1  clock; all state updates on posedge.
REQ-005 rstn  in  1  asynchronous active-low reset.
REQ-006 req  in  1  access request; it is accepted when req && ready.
REQ-007 we  in  1  1 = store, 0 = load; sampled on accept.
REQ-008 a  in  XLEN  byte address; word index = a[AW+1:2], offset = a[1:0], upper bits ignored.
REQ-009 wd  in  XLEN  store data, right-aligned (byte wd[7:0], half wd[15:0]).
REQ-010 size  in  2  00 word, 01 byte, 10 half; 11 is treated as word.
REQ-011 lunsigned  in  1  1 = zero-extend, 0 = sign-extend sub-word loads.
REQ-012 ready  out  1  block can accept a request this cycle.
REQ-013 rvalid  out  1  one-cycle pulse; rd is valid.
REQ-014 rd  out  XLEN  extended load data, held until the next rvalid.
REQ-015 err  out  1  one-cycle pulse flagging a rejected misaligned word access.

Function
REQ-016 Storage: DEPTH x 32-bit array, little-endian byte lanes, contents not reset.
REQ-017 FSM states: IDLE, SPAN_WR, SPAN_RD; ready = (state == IDLE).
REQ-018 Word access with offset 0 is accepted.
 - Store: all 4 lanes written at the accepting edge.
 - Load: rvalid = 1 and rd = word on the next cycle (latency 1).
REQ-019 Word access with offset != 0: no write; next cycle err = 1; for a load, rvalid = 1 and rd = 0 in that same cycle.
REQ-020 Byte store writes lane a[1:0] only; other lanes are preserved.
REQ-021 Byte load: rd = byte at lane a[1:0], extended per lunsigned; latency 1.
REQ-022 Half store, offset 0/1/2: writes lanes off and off+1 in one cycle.
REQ-023 Half load, offset 0/1/2: reads lanes off and off+1, extended per lunsigned; latency 1.
REQ-024 Half store, offset 3 (spanning):
 - Accept edge: lane 3 of word N <= wd[7:0]; go to SPAN_WR.
 - Next edge: lane 0 of word (N+1) mod DEPTH <= wd[15:8]; go to IDLE.
REQ-025 Half load, offset 3:
 - Accept edge: capture lane 3 of word N as the low byte; go to SPAN_RD.
 - Next edge: capture lane 0 of word (N+1) mod DEPTH as the high byte; go to IDLE.
 - rvalid is asserted the following cycle; latency 2.
REQ-026 The word index wraps: N = DEPTH-1 spans into word 0.
REQ-027 Address, data, size and lunsigned are registered on accept; input changes during SPAN_* have no effect.
REQ-028 req while ready = 0 is ignored and not queued; the master SHALL hold it.
REQ-029 Back-to-back accepts are legal in IDLE.
 - Read-after-write to the same word on consecutive accepts returns the new data.
 - Write bypass is not required; the write commits before the later array read.
REQ-030 rvalid and err are never asserted for stores, except err per REQ-019.

Reset
REQ-031 On rstn = 0, immediately: state = IDLE, ready = 1, rvalid = 0, err = 0, rd = 0.
REQ-032 Reset in SPAN_WR aborts the second-byte write; a lane-3 byte already written remains.
REQ-033 Reset in SPAN_RD discards the captured byte; no rvalid is produced.
REQ-034 Memory contents are unaffected by reset.

Verification
REQ-035 Store word 0xDEADBEEF @0x10, then load word @0x10 -> rvalid 1 cycle after accept, rd = 0xDEADBEEF.
REQ-036 Store byte 0x80 @0x12 over 0x00000000, then load byte @0x12:
 - lunsigned = 0 -> rd = 0xFFFFFF80.
 - lunsigned = 1 -> rd = 0x00000080.
 - Load word @0x10 -> 0x00800000.
REQ-037 Store half 0xA55A @0x13 with words 4 and 5 at 0 -> ready low 1 cycle; word4 = 0x5A000000, word5 = 0x000000A5; load half @0x13 signed -> rd = 0xFFFFA55A, latency 2.
REQ-038 Store half 0x1234 @ (DEPTH*4-1) -> word DEPTH-1 lane3 = 0x34, word0 lane0 = 0x12.
REQ-039 Load word @0x22 -> err pulse and rvalid with rd = 0; store word @0x21 -> err pulse, memory unchanged.
REQ-040 Assert rstn low during SPAN_WR -> ready = 1 and state IDLE asynchronously; the second byte is never written.
